// File: rtl/key_event.sv
// Key event decoder: turns a debounced active-low key level into press, short,
// long, auto-repeat and release pulses. Define KEY_REPEAT_EN to enable auto-repeat.
module key_event #(
  parameter int unsigned T_LONG   = 50_000_000,
  parameter int unsigned T_REPEAT = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_wave,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic long_active
);

  // state   | meaning
  // S_IDLE  | key released, waiting for a falling edge
  // S_PRESS | key held, timing toward a long press
  // S_HOLD  | long press reached, auto-repeating while held
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_PRESS = 3'b010,
    S_HOLD  = 3'b100
  } state_t;

  localparam logic [25:0] LONG_TC = 26'(T_LONG - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [25:0] REP_TC = 26'(T_REPEAT - 1);
`endif

  state_t      state, state_nxt;
  logic        key_d;
  logic        fall;
  logic [25:0] cnt, cnt_nxt;
  logic        press_nxt, short_nxt, long_nxt, repeat_nxt, release_nxt;

  // key_d resets to 0 so a key held through reset never looks like a new press
  assign fall = key_d & ~key_wave;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_nxt   = 1'b0;
    short_nxt   = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    release_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (fall) begin
          state_nxt = S_PRESS;
          press_nxt = 1'b1;
        end
      end
      S_PRESS: begin
        if (key_wave) begin
          state_nxt   = S_IDLE;
          cnt_nxt     = '0;
          short_nxt   = 1'b1;
          release_nxt = 1'b1;
        end else if (cnt == LONG_TC) begin
          state_nxt = S_HOLD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 26'd1;
        end
      end
      S_HOLD: begin
        if (key_wave) begin
          state_nxt   = S_IDLE;
          cnt_nxt     = '0;
          release_nxt = 1'b1;
        end else begin
`ifdef KEY_REPEAT_EN
          if (cnt == REP_TC) begin
            cnt_nxt    = '0;
            repeat_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 26'd1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      key_d         <= 1'b0;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      key_d         <= key_wave;
      cnt           <= cnt_nxt;
      press_pulse   <= press_nxt;
      short_pulse   <= short_nxt;
      long_pulse    <= long_nxt;
      repeat_pulse  <= repeat_nxt;
      release_pulse <= release_nxt;
    end
  end

  assign long_active = (state == S_HOLD);

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: expected pulse events are queued with their
// cycle number and checked by a monitor whenever any pulse output is high.
module tb_key_event;

  localparam int TL = 20;
  localparam int TR = 5;

  localparam logic [4:0] E_PRESS = 5'b10000;
  localparam logic [4:0] E_SHORT = 5'b01000;
  localparam logic [4:0] E_LONG  = 5'b00100;
  localparam logic [4:0] E_REP   = 5'b00010;
  localparam logic [4:0] E_REL   = 5'b00001;

  logic clk = 1'b0;
  logic rst;
  logic key_wave;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, long_active;

  key_event #(.T_LONG(TL), .T_REPEAT(TR)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_wave     (key_wave),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .release_pulse(release_pulse),
    .long_active  (long_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] ev;
    logic       la;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c0, c1;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_ev(input int c, input logic [4:0] e, input logic la);
    exp_t x;
    x.cyc = c;
    x.ev  = e;
    x.la  = la;
    q.push_back(x);
  endfunction

  // monitor
  logic [4:0] got;
  exp_t       head;
  always @(negedge clk) begin
    got = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse};
    if (got != 5'b0) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event cyc=%0d got=%b la=%b required=none", cyc, got, long_active);
      end else begin
        head = q.pop_front();
        if (head.cyc != cyc || head.ev != got || head.la != long_active) begin
          bad++;
          $display("FAIL event got cyc=%0d ev=%b la=%b required cyc=%0d ev=%b la=%b",
                   cyc, got, long_active, head.cyc, head.ev, head.la);
        end
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    key_wave = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d required=0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    rst      = 1'b1;
    key_wave = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, long_active} != 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b required=000000",
               {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, long_active});
    end
    rst = 1'b0;

    // idle with key released
    drive(1'b1, 50);
    total++;
    if ({press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, long_active} != 6'b0) begin
      bad++;
      $display("FAIL idle_outputs got=%b required=000000",
               {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, long_active});
    end
    drain("idle");

    // short press of 8 cycles
    c0 = cyc;
    expect_ev(c0 + 1, E_PRESS, 1'b0);
    expect_ev(c0 + 9, E_SHORT | E_REL, 1'b0);
    drive(1'b0, 8);
    drive(1'b1, 6);
    drain("short_press");

    // 32-cycle hold
    c0 = cyc;
    expect_ev(c0 + 1, E_PRESS, 1'b0);
    expect_ev(c0 + 21, E_LONG, 1'b1);
`ifdef KEY_REPEAT_EN
    expect_ev(c0 + 26, E_REP, 1'b1);
    expect_ev(c0 + 31, E_REP, 1'b1);
`endif
    expect_ev(c0 + 33, E_REL, 1'b0);
    drive(1'b0, 32);
    drive(1'b1, 5);
    drain("long_hold");

    // release exactly at the long terminal count
    c0 = cyc;
    expect_ev(c0 + 1, E_PRESS, 1'b0);
    expect_ev(c0 + 21, E_SHORT | E_REL, 1'b0);
    drive(1'b0, 20);
    drive(1'b1, 5);
    drain("release_at_long_tc");

    // release exactly at the second repeat terminal count
    c0 = cyc;
    expect_ev(c0 + 1, E_PRESS, 1'b0);
    expect_ev(c0 + 21, E_LONG, 1'b1);
`ifdef KEY_REPEAT_EN
    expect_ev(c0 + 26, E_REP, 1'b1);
`endif
    expect_ev(c0 + 31, E_REL, 1'b0);
    drive(1'b0, 30);
    drive(1'b1, 5);
    drain("release_at_repeat_tc");

    // key held through reset, then a fresh press
    rst      = 1'b1;
    key_wave = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 40);
    drive(1'b1, 3);
    c1 = cyc;
    expect_ev(c1 + 1, E_PRESS, 1'b0);
    expect_ev(c1 + 7, E_SHORT | E_REL, 1'b0);
    drive(1'b0, 6);
    drive(1'b1, 4);
    drain("held_through_reset");

    // reset in the middle of a press drops everything after it
    c0 = cyc;
    expect_ev(c0 + 1, E_PRESS, 1'b0);
    drive(1'b0, 4);
    rst = 1'b1;
    drive(1'b0, 2);
    rst = 1'b0;
    drive(1'b0, 30);
    drive(1'b1, 4);
    drain("reset_mid_press");

    // 60-cycle hold; with repeat the release lands on a repeat terminal count
    c0 = cyc;
    expect_ev(c0 + 1, E_PRESS, 1'b0);
    expect_ev(c0 + 21, E_LONG, 1'b1);
`ifdef KEY_REPEAT_EN
    for (int k = 1; k <= 7; k++) expect_ev(c0 + 21 + TR * k, E_REP, 1'b1);
`endif
    expect_ev(c0 + 61, E_REL, 1'b0);
    drive(1'b0, 60);
    drive(1'b1, 5);
    drain("hold_60");

    // press accepted the cycle right after a release
    c0 = cyc;
    expect_ev(c0 + 1, E_PRESS, 1'b0);
    expect_ev(c0 + 4, E_SHORT | E_REL, 1'b0);
    expect_ev(c0 + 5, E_PRESS, 1'b0);
    expect_ev(c0 + 8, E_SHORT | E_REL, 1'b0);
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 3);
    drive(1'b1, 6);
    drain("back_to_back");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
